apb_mem_slave: RTL and testbench
================================

Name: apb_mem_slave

Overview:
- APB completer that consumes the bridge's APB master outputs (Psel, Penable, Pwrite, Paddr, Pdata) and terminates transfers into a word-addressed register memory.
- Inserts a programmable number of wait states, returns read data, and flags address errors via Pslverr.
- Sits directly downstream of the AHB-to-APB bridge in the rclk domain and is the bench's reference APB endpoint.

Parameters:
- ADDR_WIDTH, 32, width of Paddr.
- DATA_WIDTH, 32, width of Pdata/Prdata/memory words.
- DEPTH, 256, number of memory words; must be a power of two, 2 to 4096.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.
- WAIT_CYCLES, 1, wait states inserted per transfer (Pready low in access phase), 0 to 15.

Ports:
- Pclk  input  1  APB clock (bridge rclk).
- Presetn  input  1  asynchronous active-low reset.
- Psel  input  1  slave select from APB master.
- Penable  input  1  access-phase strobe.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  ADDR_WIDTH  byte address.
- Pdata  input  DATA_WIDTH  write data.
- Prdata  output  DATA_WIDTH  read data, valid while Pready=1 on a read.
- Pready  output  1  transfer completion.
- Pslverr  output  1  error response, valid only while Pready=1.
- memory_out  output  DATA_WIDTH  data of the last successfully committed write.

Behaviour:
- One clock (Pclk); reset is asynchronous and active-low (Presetn), sampled on its falling edge independent of Pclk.
- Reset values:
  - Prdata=0, Pready=0, Pslverr=0, memory_out=0.
  - Every memory word = 0.
  - FSM = IDLE, wait counter = 0.
- FSM states: IDLE, WAIT, ACCESS. All outputs are registered.
- IDLE:
  - Psel=1 and Penable=0 at a Pclk edge: latch Paddr, Pwrite, Pdata and compute err.
  - Next state is ACCESS if WAIT_CYCLES=0; otherwise WAIT with counter=WAIT_CYCLES.
  - Psel=1 with Penable=1 in IDLE (no setup phase) is ignored; state stays IDLE.
- WAIT:
  - Pready=0. Counter decrements each edge while Psel=1.
  - When counter=1 at an edge, go to ACCESS.
  - Psel=0 at any edge: abort to IDLE, no write.
- ACCESS:
  - Pready=1; Pslverr=err.
  - Prdata is loaded on the edge entering ACCESS: mem[idx] for a read without err, else 0.
  - At the next edge with Psel=1 and Penable=1:
    - If write and !err: mem[idx] <= latched Pdata and memory_out <= latched Pdata.
    - Go to IDLE and drop Pready/Pslverr.
  - Psel=0 at that edge: IDLE, no write (protocol abort).
- Latency: a transfer is setup + WAIT_CYCLES + 1 access cycles; minimum 2 cycles at WAIT_CYCLES=0.
- Back-to-back transfers: the master returns to setup the cycle after ACCESS. IDLE samples it, so there is no dead cycle beyond the APB-mandated setup.
- Address decode:
  - off = Paddr - BASE_ADDR (ADDR_WIDTH bits, unsigned); idx = off[log2(DEPTH)+1:2].
  - err = (Paddr < BASE_ADDR) or (off >= DEPTH*4) or (Paddr[1:0] != 0).
  - On err: write suppressed, Prdata=0.
- Prdata holds its last value after ACCESS until the next read load; writes never alter Prdata.
- Latched address/data are used for the whole transfer. Changes on Paddr/Pdata during WAIT/ACCESS are ignored.
- Reset asserted mid-transfer: immediate return to reset values, pending write discarded, memory cleared.

Test Plan:
- Reset: Presetn=0 for 3 cycles then release → Pready=0, Pslverr=0, Prdata=0, memory_out=0; a read of 0x10 returns 0.
- Write then read, WAIT_CYCLES=1:
  - Write 0x0000_0008 <= 0xDEAD_BEEF → Pready high exactly in the 3rd cycle after setup; memory_out=0xDEADBEEF.
  - Read 0x8 → Prdata=0xDEADBEEF with Pslverr=0.
- Errors:
  - Write 0x0000_0400 (DEPTH=256, out of range) → Pslverr=1 with Pready=1, memory_out unchanged.
  - Write 0x0000_0006 (misaligned) → Pslverr=1, no write.
  - Read 0x400 → Prdata=0, Pslverr=1.
- Back-to-back, WAIT_CYCLES=0: writes to 0x0, 0x4, 0x3FC with data 1, 2, 3, each 2 cycles → reads return 1, 2, 3, and the 0x3FC boundary word is not an error.
- Abort: during WAIT on a write to 0x20, drop Psel → FSM returns to IDLE, Pready never asserts, a later read of 0x20 returns 0.
- Reset mid-transfer: Presetn low while in ACCESS of a write to 0xC → write not committed, all outputs 0 asynchronously, read 0xC returns 0.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB completer terminating transfers into a word-addressed register memory.
// Inserts WAIT_CYCLES wait states per transfer and flags address errors on Pslverr.
module apb_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    WAIT_CYCLES = 1
) (
  input  logic                  Pclk,
  input  logic                  Presetn,
  input  logic                  Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic [DATA_WIDTH-1:0] memory_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    write_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [DATA_WIDTH-1:0]   prdata_r;
  logic                    pready_r;
  logic                    pslverr_r;
  logic [DATA_WIDTH-1:0]   memory_out_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic [ADDR_WIDTH-1:0]   off_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    err_s;

  // Address decode of the live bus address, consumed only in the setup phase.
  always_comb begin
    off_s = Paddr - BASE_ADDR;
    idx_s = off_s[IDX_W+1:2];
    // BASE_ADDR is word aligned, so off_s[1:0] equals Paddr[1:0].
    err_s = (Paddr < BASE_ADDR) || (off_s >= SPAN) || (off_s[1:0] != 2'b00);
  end

  // Transfer FSM, memory array and all registered bus outputs.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      idx_r        <= '0;
      write_r      <= 1'b0;
      err_r        <= 1'b0;
      data_r       <= '0;
      prdata_r     <= '0;
      pready_r     <= 1'b0;
      pslverr_r    <= 1'b0;
      memory_out_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Psel && !Penable) begin
            idx_r   <= idx_s;
            write_r <= Pwrite;
            data_r  <= Pdata;
            err_r   <= err_s;
            if (WAIT_CYCLES == 0) begin
              state_r   <= ST_ACCESS;
              pready_r  <= 1'b1;
              pslverr_r <= err_s;
              if (!Pwrite) begin
                prdata_r <= err_s ? '0 : mem_r[idx_s];
              end
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_INIT;
            end
          end
        end

        ST_WAIT: begin
          if (!Psel) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
          end else if (cnt_r == 4'd1) begin
            state_r   <= ST_ACCESS;
            cnt_r     <= 4'd0;
            pready_r  <= 1'b1;
            pslverr_r <= err_r;
            if (!write_r) begin
              prdata_r <= err_r ? '0 : mem_r[idx_r];
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end

        ST_ACCESS: begin
          if (!Psel) begin
            state_r   <= ST_IDLE;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
          end else if (Penable) begin
            if (write_r && !err_r) begin
              mem_r[idx_r] <= data_r;
              memory_out_r <= data_r;
            end
            state_r   <= ST_IDLE;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= 4'd0;
          pready_r  <= 1'b0;
          pslverr_r <= 1'b0;
        end
      endcase
    end
  end

  assign Prdata     = prdata_r;
  assign Pready     = pready_r;
  assign Pslverr    = pslverr_r;
  assign memory_out = memory_out_r;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one instance with one wait state, one with none.
// Bus index 1 drives the WAIT_CYCLES=1 instance, index 0 the WAIT_CYCLES=0 instance.
module tb_apb_mem_slave;

  logic        clk;
  logic        rst_n;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pdata   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [31:0] mem_out [2];

  int checks;
  int errors;

  logic [31:0] rd;
  logic        er;
  int          cyc;

  apb_mem_slave #(.WAIT_CYCLES(0)) dut0 (
    .Pclk(clk), .Presetn(rst_n), .Psel(psel[0]), .Penable(penable[0]),
    .Pwrite(pwrite[0]), .Paddr(paddr[0]), .Pdata(pdata[0]), .Prdata(prdata[0]),
    .Pready(pready[0]), .Pslverr(pslverr[0]), .memory_out(mem_out[0])
  );

  apb_mem_slave #(.WAIT_CYCLES(1)) dut1 (
    .Pclk(clk), .Presetn(rst_n), .Psel(psel[1]), .Penable(penable[1]),
    .Pwrite(pwrite[1]), .Paddr(paddr[1]), .Pdata(pdata[1]), .Prdata(prdata[1]),
    .Pready(pready[1]), .Pslverr(pslverr[1]), .memory_out(mem_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the access.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int cycles);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pdata[d]   = wdata;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    cycles = 2;
    @(negedge clk);
    while (!pready[d] && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk("ready_seen", {31'd0, pready[d]}, 32'd1);
    rdata = prdata[d];
    err   = pslverr[d];
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = 32'd0; pdata[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state on both instances.
    chk("rst_pready1",  {31'd0, pready[1]},  32'd0);
    chk("rst_pslverr1", {31'd0, pslverr[1]}, 32'd0);
    chk("rst_prdata1",  prdata[1],  32'd0);
    chk("rst_memout1",  mem_out[1], 32'd0);
    chk("rst_pready0",  {31'd0, pready[0]},  32'd0);
    chk("rst_memout0",  mem_out[0], 32'd0);
    xfer(1, 1'b0, 32'h0000_0010, 32'd0, rd, er, cyc);
    chk("rst_rd10", rd, 32'd0);

    // Write then read with one wait state.
    xfer(1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, rd, er, cyc);
    chk("wr8_cycles", cyc, 32'd3);
    chk("wr8_err",    {31'd0, er}, 32'd0);
    chk("wr8_memout", mem_out[1], 32'hDEAD_BEEF);
    xfer(1, 1'b0, 32'h0000_0008, 32'd0, rd, er, cyc);
    chk("rd8_data",   rd, 32'hDEAD_BEEF);
    chk("rd8_err",    {31'd0, er}, 32'd0);
    chk("rd8_cycles", cyc, 32'd3);

    // Error responses.
    xfer(1, 1'b1, 32'h0000_0400, 32'h1111_1111, rd, er, cyc);
    chk("wr400_err",    {31'd0, er}, 32'd1);
    chk("wr400_memout", mem_out[1], 32'hDEAD_BEEF);
    xfer(1, 1'b1, 32'h0000_0006, 32'h2222_2222, rd, er, cyc);
    chk("wr6_err",    {31'd0, er}, 32'd1);
    chk("wr6_memout", mem_out[1], 32'hDEAD_BEEF);
    xfer(1, 1'b0, 32'h0000_0004, 32'd0, rd, er, cyc);
    chk("rd4_after_wr6", rd, 32'd0);
    xfer(1, 1'b0, 32'h0000_0008, 32'd0, rd, er, cyc);
    chk("rd8_again", rd, 32'hDEAD_BEEF);
    xfer(1, 1'b0, 32'h0000_0400, 32'd0, rd, er, cyc);
    chk("rd400_data", rd, 32'd0);
    chk("rd400_err",  {31'd0, er}, 32'd1);

    // Back-to-back with no wait states, including the top word.
    xfer(0, 1'b1, 32'h0000_0000, 32'd1, rd, er, cyc);
    chk("b2b_w0_cycles", cyc, 32'd2);
    chk("b2b_w0_err",    {31'd0, er}, 32'd0);
    xfer(0, 1'b1, 32'h0000_0004, 32'd2, rd, er, cyc);
    chk("b2b_w4_cycles", cyc, 32'd2);
    xfer(0, 1'b1, 32'h0000_03FC, 32'd3, rd, er, cyc);
    chk("b2b_w3fc_cycles", cyc, 32'd2);
    chk("b2b_w3fc_err",    {31'd0, er}, 32'd0);
    chk("b2b_memout",      mem_out[0], 32'd3);
    xfer(0, 1'b0, 32'h0000_0000, 32'd0, rd, er, cyc);
    chk("b2b_r0", rd, 32'd1);
    xfer(0, 1'b0, 32'h0000_0004, 32'd0, rd, er, cyc);
    chk("b2b_r4", rd, 32'd2);
    xfer(0, 1'b0, 32'h0000_03FC, 32'd0, rd, er, cyc);
    chk("b2b_r3fc",     rd, 32'd3);
    chk("b2b_r3fc_err", {31'd0, er}, 32'd0);
    chk("b2b_r3fc_cyc", cyc, 32'd2);

    // Abort a write during its wait state.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0000_0020; pdata[1] = 32'h1234_5678;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    chk("abort_wait_pready", {31'd0, pready[1]}, 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_pready", {31'd0, pready[1]}, 32'd0);
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h0000_0020, 32'd0, rd, er, cyc);
    chk("abort_rd20",     rd, 32'd0);
    chk("abort_rd20_cyc", cyc, 32'd3);
    chk("abort_memout",   mem_out[1], 32'hDEAD_BEEF);

    // Reset during the access phase of a write.
    xfer(1, 1'b0, 32'h0000_0008, 32'd0, rd, er, cyc);
    chk("pre_rst_rd8", rd, 32'hDEAD_BEEF);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0000_000C; pdata[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_access_pready", {31'd0, pready[1]}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_pready",  {31'd0, pready[1]},  32'd0);
    chk("mid_rst_pslverr", {31'd0, pslverr[1]}, 32'd0);
    chk("mid_rst_prdata",  prdata[1],  32'd0);
    chk("mid_rst_memout",  mem_out[1], 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'h0000_000C, 32'd0, rd, er, cyc);
    chk("post_rst_rdC", rd, 32'd0);
    xfer(1, 1'b0, 32'h0000_0008, 32'd0, rd, er, cyc);
    chk("post_rst_rd8", rd, 32'd0);
    chk("post_rst_memout", mem_out[1], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
